alu_secuenciador: RTL and testbench

//  Initiator for the 4-bit-opcode ALU (ops 1100 AND, 1101 OR, 1010 ADD+flag, 1011 SUB-flag, 1110 SHL).
//  - Holds a small register file.
//  - Accepts one command at a time over a valid/ready handshake and reads both operands.
//  - Drives the ALU operand/control ports, captures ALUresult_i, writes the result back and

---
 rtl/alu_secuenciador.sv | 168 ++++++++++++++++
 tb/tb_alu_secuenciador.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_secuenciador.sv
// alu_secuenciador: command sequencer in front of the 4-bit-opcode ALU.
// Holds a small register file, accepts one command at a time, reads both
// operands into registered ALU ports, captures the ALU result, writes it back
// into the register file and returns it to the consumer with N/Z/error flags.
// Sequence per command: IDLE -> EXEC -> WB -> RESP -> IDLE.
module alu_secuenciador #(
  parameter  int ANCHO = 16,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [AW-1:0]    cmd_ra_i,
  input  logic [AW-1:0]    cmd_rb_i,
  input  logic [AW-1:0]    cmd_rd_i,
  input  logic             cmd_flagin_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [ANCHO-1:0] wr_data_i,
  output logic             wr_busy_o,
  output logic [ANCHO-1:0] ALUa_o,
  output logic [ANCHO-1:0] ALUb_o,
  output logic             ALUflagin_o,
  output logic [3:0]       ALUcontrol_o,
  input  logic [ANCHO-1:0] ALUresult_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ANCHO-1:0] res_data_o,
  output logic             res_z_o,
  output logic             res_n_o,
  output logic             res_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state_r;
  logic [ANCHO-1:0]  regs_r [NREG];
  logic [AW-1:0]     rd_r;

  logic              op_ok_s;
  logic [ANCHO-1:0]  res_next_s;
  logic              rf_we_s;
  logic [AW-1:0]     rf_idx_s;
  logic [ANCHO-1:0]  rf_data_s;

  // True only for the five opcodes the ALU implements.
  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      4'b1100, 4'b1101, 4'b1010, 4'b1011, 4'b1110: ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Result to capture in WB: the ALU output for legal opcodes, zero otherwise.
  always_comb begin
    op_ok_s    = op_legal(ALUcontrol_o);
    res_next_s = {ANCHO{1'b0}};
    if (op_ok_s) begin
      res_next_s = ALUresult_i;
    end else begin
      res_next_s = {ANCHO{1'b0}};
    end
  end

  // Register-file write port: the WB writeback owns the port in WB, so a host
  // write arriving in that cycle is dropped; otherwise the host writes freely.
  always_comb begin
    rf_we_s   = 1'b0;
    rf_idx_s  = {AW{1'b0}};
    rf_data_s = {ANCHO{1'b0}};
    if (state_r == ST_WB) begin
      rf_we_s   = op_ok_s;
      rf_idx_s  = rd_r;
      rf_data_s = ALUresult_i;
    end else begin
      rf_we_s   = wr_en_i;
      rf_idx_s  = wr_addr_i;
      rf_data_s = wr_data_i;
    end
  end

  // Register file storage, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {ANCHO{1'b0}};
      end
    end else if (rf_we_s) begin
      regs_r[rf_idx_s] <= rf_data_s;
    end
  end

  // Command sequencer with all outputs registered. Operands are read from the
  // register file at the accept edge, so a same-cycle host write to ra/rb is
  // not seen (old value is used).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cmd_ready_o  <= 1'b1;
      wr_busy_o    <= 1'b0;
      ALUa_o       <= {ANCHO{1'b0}};
      ALUb_o       <= {ANCHO{1'b0}};
      ALUflagin_o  <= 1'b0;
      ALUcontrol_o <= 4'b0000;
      rd_r         <= {AW{1'b0}};
      res_valid_o  <= 1'b0;
      res_data_o   <= {ANCHO{1'b0}};
      res_z_o      <= 1'b0;
      res_n_o      <= 1'b0;
      res_err_o    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            ALUa_o       <= regs_r[cmd_ra_i];
            ALUb_o       <= regs_r[cmd_rb_i];
            ALUflagin_o  <= cmd_flagin_i;
            ALUcontrol_o <= cmd_op_i;
            rd_r         <= cmd_rd_i;
            cmd_ready_o  <= 1'b0;
            state_r      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          wr_busy_o <= 1'b1;
          state_r   <= ST_WB;
        end
        ST_WB: begin
          wr_busy_o   <= 1'b0;
          res_data_o  <= res_next_s;
          res_z_o     <= (res_next_s == {ANCHO{1'b0}});
          res_n_o     <= res_next_s[ANCHO-1];
          res_err_o   <= ~op_ok_s;
          res_valid_o <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready_i) begin
            res_valid_o  <= 1'b0;
            ALUa_o       <= {ANCHO{1'b0}};
            ALUb_o       <= {ANCHO{1'b0}};
            ALUflagin_o  <= 1'b0;
            ALUcontrol_o <= 4'b0000;
            cmd_ready_o  <= 1'b1;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_o <= 1'b1;
          wr_busy_o   <= 1'b0;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuenciador.sv
// Directed self-checking bench for alu_secuenciador with a behavioural ALU.
module tb_alu_secuenciador;

  localparam int ANCHO = 16;
  localparam int NREG  = 8;
  localparam int AW    = 3;

  localparam logic [3:0] OP_AND = 4'b1100;
  localparam logic [3:0] OP_OR  = 4'b1101;
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b1110;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [AW-1:0]    cmd_ra;
  logic [AW-1:0]    cmd_rb;
  logic [AW-1:0]    cmd_rd;
  logic             cmd_flagin;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [ANCHO-1:0] wr_data;
  logic             wr_busy;
  logic [ANCHO-1:0] alu_a;
  logic [ANCHO-1:0] alu_b;
  logic             alu_flagin;
  logic [3:0]       alu_control;
  logic [ANCHO-1:0] alu_result;
  logic             res_valid;
  logic             res_ready;
  logic [ANCHO-1:0] res_data;
  logic             res_z;
  logic             res_n;
  logic             res_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_secuenciador #(.ANCHO(ANCHO), .NREG(NREG)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_ra_i     (cmd_ra),
    .cmd_rb_i     (cmd_rb),
    .cmd_rd_i     (cmd_rd),
    .cmd_flagin_i (cmd_flagin),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_busy_o    (wr_busy),
    .ALUa_o       (alu_a),
    .ALUb_o       (alu_b),
    .ALUflagin_o  (alu_flagin),
    .ALUcontrol_o (alu_control),
    .ALUresult_i  (alu_result),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .res_z_o      (res_z),
    .res_n_o      (res_n),
    .res_err_o    (res_err)
  );

  // Behavioural ALU; unknown opcodes return a non-zero pattern.
  always_comb begin
    case (alu_control)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b + {15'd0, alu_flagin};
      OP_SUB:  alu_result = alu_a - alu_b - {15'd0, alu_flagin};
      OP_SHL:  alu_result = (alu_b >= 16'd16) ? 16'h0000 : (alu_a << alu_b[3:0]);
      default: alu_result = 16'hDEAD;
    endcase
  end

  task automatic host_write(input logic [AW-1:0] a, input logic [ANCHO-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Presents a command and returns at the falling edge after it was accepted (EXEC).
  task automatic send_cmd(input logic [3:0] op, input logic [AW-1:0] ra,
                          input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                          input logic fl);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd; cmd_flagin = fl;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout cmd_ready=%b required=1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res();
    int k;
    k = 0;
    while (res_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL res_timeout res_valid=%b required=1", res_valid);
    end
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", res_valid); end
    n_checks++; if ({alu_a, alu_b, alu_control, alu_flagin} !== 37'd0) begin n_fail++; $display("FAIL rst_alu got a=%h b=%h exp 0", alu_a, alu_b); end
    n_checks++; if ({res_data, res_z, res_n, res_err, wr_busy} !== 20'd0) begin n_fail++; $display("FAIL rst_res got data=%h z=%b n=%b err=%b busy=%b exp 0", res_data, res_z, res_n, res_err, wr_busy); end
  endtask

  task automatic test_add();
    host_write(3'd1, 16'h0003);
    host_write(3'd2, 16'h0005);
    send_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 1'b1);
    n_checks++; if (alu_a !== 16'h0003 || alu_b !== 16'h0005) begin n_fail++; $display("FAIL add_operands got a=%h b=%h exp 0003 0005", alu_a, alu_b); end
    n_checks++; if (alu_control !== OP_ADD || alu_flagin !== 1'b1) begin n_fail++; $display("FAIL add_ctrl got op=%b fl=%b exp 1010 1", alu_control, alu_flagin); end
    n_checks++; if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL add_exec got ready=%b valid=%b exp 0 0", cmd_ready, res_valid); end
    @(negedge clk);
    n_checks++; if (wr_busy !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL add_wb got busy=%b valid=%b exp 1 0", wr_busy, res_valid); end
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b1 || wr_busy !== 1'b0) begin n_fail++; $display("FAIL add_latency got valid=%b busy=%b exp 1 0", res_valid, wr_busy); end
    n_checks++; if (res_data !== 16'h0009 || res_z !== 1'b0 || res_n !== 1'b0 || res_err !== 1'b0) begin n_fail++; $display("FAIL add_result got %h z=%b n=%b err=%b exp 0009 0 0 0", res_data, res_z, res_n, res_err); end
    take_res();
    n_checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || alu_a !== 16'h0000) begin n_fail++; $display("FAIL add_return got ready=%b valid=%b a=%h exp 1 0 0000", cmd_ready, res_valid, alu_a); end
    n_checks++; if (res_data !== 16'h0009) begin n_fail++; $display("FAIL add_hold got %h exp 0009", res_data); end
    send_cmd(OP_OR, 3'd3, 3'd0, 3'd7, 1'b0);
    n_checks++; if (alu_a !== 16'h0009) begin n_fail++; $display("FAIL add_writeback got r3=%h exp 0009", alu_a); end
    wait_res();
    take_res();
  endtask

  task automatic test_sub_backpressure();
    host_write(3'd1, 16'h0005);
    send_cmd(OP_SUB, 3'd1, 3'd2, 3'd4, 1'b1);
    wait_res();
    n_checks++; if (res_data !== 16'hFFFF || res_n !== 1'b1 || res_z !== 1'b0) begin n_fail++; $display("FAIL sub_result got %h n=%b z=%b exp FFFF 1 0", res_data, res_n, res_z); end
    cmd_valid = 1'b1; cmd_op = OP_AND; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_rd = 3'd7; cmd_flagin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 16'hFFFF) begin n_fail++; $display("FAIL sub_stall got ready=%b valid=%b data=%h exp 0 1 FFFF", cmd_ready, res_valid, res_data); end
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 16'hFFFF) begin n_fail++; $display("FAIL sub_release got ready=%b valid=%b data=%h exp 1 0 FFFF", cmd_ready, res_valid, res_data); end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++; if (alu_control !== OP_AND || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL sub_second_accept got op=%b ready=%b exp 1100 0", alu_control, cmd_ready); end
    wait_res();
    n_checks++; if (res_data !== 16'h0005) begin n_fail++; $display("FAIL sub_second_result got %h exp 0005", res_data); end
    take_res();
  endtask

  task automatic test_and_wb_collision();
    host_write(3'd1, 16'hF0F0);
    host_write(3'd2, 16'h0F0F);
    host_write(3'd4, 16'h1234);
    send_cmd(OP_AND, 3'd1, 3'd2, 3'd5, 1'b0);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF;
    n_checks++; if (wr_busy !== 1'b1) begin n_fail++; $display("FAIL and_busy got %b exp 1", wr_busy); end
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++; if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_z !== 1'b1 || res_n !== 1'b0) begin n_fail++; $display("FAIL and_result got valid=%b %h z=%b n=%b exp 1 0000 1 0", res_valid, res_data, res_z, res_n); end
    take_res();
    send_cmd(OP_OR, 3'd4, 3'd0, 3'd7, 1'b0);
    n_checks++; if (alu_a !== 16'h1234) begin n_fail++; $display("FAIL and_dropped_write got r4=%h exp 1234", alu_a); end
    wait_res();
    take_res();
  endtask

  task automatic test_shl_wrap();
    host_write(3'd1, 16'h0001);
    host_write(3'd2, 16'h000F);
    send_cmd(OP_SHL, 3'd1, 3'd2, 3'd7, 1'b0);
    wait_res();
    n_checks++; if (res_data !== 16'h8000 || res_n !== 1'b1 || res_z !== 1'b0) begin n_fail++; $display("FAIL shl15 got %h n=%b z=%b exp 8000 1 0", res_data, res_n, res_z); end
    take_res();
    host_write(3'd2, 16'h0010);
    send_cmd(OP_SHL, 3'd1, 3'd2, 3'd7, 1'b0);
    wait_res();
    n_checks++; if (res_data !== 16'h0000 || res_z !== 1'b1 || res_n !== 1'b0) begin n_fail++; $display("FAIL shl16 got %h z=%b n=%b exp 0000 1 0", res_data, res_z, res_n); end
    take_res();
    host_write(3'd1, 16'hFFFF);
    host_write(3'd2, 16'h0001);
    send_cmd(OP_ADD, 3'd1, 3'd2, 3'd7, 1'b0);
    wait_res();
    n_checks++; if (res_data !== 16'h0000 || res_z !== 1'b1) begin n_fail++; $display("FAIL add_wrap got %h z=%b exp 0000 1", res_data, res_z); end
    take_res();
  endtask

  task automatic test_illegal();
    host_write(3'd6, 16'h5A5A);
    send_cmd(4'b0000, 3'd1, 3'd2, 3'd6, 1'b0);
    wait_res();
    n_checks++; if (res_err !== 1'b1 || res_data !== 16'h0000 || res_z !== 1'b1 || res_n !== 1'b0) begin n_fail++; $display("FAIL illegal_result got err=%b %h z=%b n=%b exp 1 0000 1 0", res_err, res_data, res_z, res_n); end
    take_res();
    send_cmd(OP_OR, 3'd6, 3'd0, 3'd7, 1'b0);
    n_checks++; if (alu_a !== 16'h5A5A) begin n_fail++; $display("FAIL illegal_no_wb got r6=%h exp 5A5A", alu_a); end
    wait_res();
    n_checks++; if (res_err !== 1'b0 || res_data !== 16'h5A5A) begin n_fail++; $display("FAIL legal_after_illegal got err=%b %h exp 0 5A5A", res_err, res_data); end
    take_res();
  endtask

  task automatic test_reset_mid();
    send_cmd(OP_ADD, 3'd1, 3'd6, 3'd3, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || wr_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got ready=%b valid=%b busy=%b exp 1 0 0", cmd_ready, res_valid, wr_busy); end
    n_checks++; if ({alu_a, alu_b, alu_control, alu_flagin} !== 37'd0) begin n_fail++; $display("FAIL midrst_alu got a=%h b=%h op=%b exp 0", alu_a, alu_b, alu_control); end
    n_checks++; if (res_data !== 16'h0000 || res_err !== 1'b0) begin n_fail++; $display("FAIL midrst_res got %h err=%b exp 0000 0", res_data, res_err); end
    send_cmd(OP_OR, 3'd1, 3'd6, 3'd7, 1'b0);
    n_checks++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin n_fail++; $display("FAIL midrst_regs got r1=%h r6=%h exp 0000 0000", alu_a, alu_b); end
    wait_res();
    n_checks++; if (res_data !== 16'h0000 || res_z !== 1'b1) begin n_fail++; $display("FAIL midrst_result got %h z=%b exp 0000 1", res_data, res_z); end
    take_res();
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid = 1'b0; cmd_op = 4'b0000; cmd_ra = 3'd0; cmd_rb = 3'd0;
    cmd_rd = 3'd0; cmd_flagin = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    res_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_backpressure();
    test_and_wb_collision();
    test_shl_wrap();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
